axi4_lite_csr_regs: RTL

//   AXI4-Lite slave register bank. It terminates the PS-side AXI4-Lite control bus and holds the dataplane CSRs.
//   It drives control fields into the PL datapath, samples status back, and aggregates event interrupts into one irq line.
//   It is the DUT behind the axi_if write/read tasks used by the CSR testcases.

---
 rtl/axi4_lite_csr_regs.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_csr_regs.sv
// AXI4-Lite slave CSR bank: CTRL/STATUS/SCRATCH/VERSION plus sticky event IRQs.
// Independent single-outstanding write and read channels; irq_o is registered.
module axi4_lite_csr_regs #(
  parameter int          ADDR_W  = 8,
  parameter logic [31:0] VERSION = 32'h0001_0000,
  parameter int          N_IRQ   = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       ctrl_o,
  input  logic [31:0]       status_i,
  input  logic [N_IRQ-1:0]  irq_event_i,
  output logic              irq_o
);
  localparam int IW = ADDR_W - 2;
  localparam logic [0:0] W_IDLE = 1'b0, W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [IW-1:0] A_CTRL    = IW'(0);
  localparam logic [IW-1:0] A_STATUS  = IW'(1);
  localparam logic [IW-1:0] A_SCRATCH = IW'(2);
  localparam logic [IW-1:0] A_VERSION = IW'(3);
  localparam logic [IW-1:0] A_IRQ_ST  = IW'(4);
  localparam logic [IW-1:0] A_IRQ_EN  = IW'(5);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        strb;
  } wr_req_t;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  logic             rdy_en;
  logic [0:0]       w_state, r_state;
  logic             aw_held, w_held;
  wr_req_t          req_q;
  logic [31:0]      ctrl_q, scratch_q;
  logic [N_IRQ-1:0] irq_st_q, irq_en_q, irq_clr;

  logic              aw_fire, w_fire, ar_fire, commit, wr_hit;
  logic [ADDR_W-1:0] wr_addr;
  logic [IW-1:0]     wr_idx;
  logic [31:0]       wr_data, bmask, en_merged, rd_val;
  logic [3:0]        wr_strb;
  logic              rd_err;

  // Ready outputs stay low until the first edge after reset release.
  assign s_awready = rdy_en && (w_state == W_IDLE) && !aw_held;
  assign s_wready  = rdy_en && (w_state == W_IDLE) && !w_held;
  assign s_arready = rdy_en && (r_state == R_IDLE);
  assign aw_fire   = s_awvalid && s_awready;
  assign w_fire    = s_wvalid && s_wready;
  assign ar_fire   = s_arvalid && s_arready;

  // A channel taken on this edge is used directly, so commit happens as soon as both are present.
  assign wr_addr = aw_held ? req_q.addr : s_awaddr;
  assign wr_data = w_held ? req_q.data : s_wdata;
  assign wr_strb = w_held ? req_q.strb : s_wstrb;
  assign commit  = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_idx  = wr_addr[ADDR_W-1:2];
  assign wr_hit  = (wr_idx <= A_IRQ_EN);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign bmask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  assign en_merged = merge(32'(irq_en_q), wr_data, bmask);
  assign ctrl_o    = ctrl_q;

  always_comb begin
    irq_clr = '0;
    if (commit && wr_idx == A_IRQ_ST) irq_clr = wr_data[N_IRQ-1:0] & bmask[N_IRQ-1:0];
  end

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (s_araddr[ADDR_W-1:2])
      A_CTRL:    rd_val = ctrl_q;
      A_STATUS:  rd_val = status_i;
      A_SCRATCH: rd_val = scratch_q;
      A_VERSION: rd_val = VERSION;
      A_IRQ_ST:  rd_val = 32'(irq_st_q);
      A_IRQ_EN:  rd_val = 32'(irq_en_q);
      default:   rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      req_q    <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_held    <= 1'b1;
            req_q.addr <= s_awaddr;
          end
          if (w_fire) begin
            w_held     <= 1'b1;
            req_q.data <= s_wdata;
            req_q.strb <= s_wstrb;
          end
          if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            s_bvalid <= 1'b1;
            s_bresp  <= wr_hit ? OKAY : SLVERR;
            w_state  <= W_RESP;
          end
        end
        default: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      irq_en_q  <= '0;
      irq_st_q  <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (commit && wr_idx == A_CTRL)    ctrl_q    <= merge(ctrl_q, wr_data, bmask);
      if (commit && wr_idx == A_SCRATCH) scratch_q <= merge(scratch_q, wr_data, bmask);
      if (commit && wr_idx == A_IRQ_EN)  irq_en_q  <= en_merged[N_IRQ-1:0];
      // A new event wins over a simultaneous W1C of the same bit.
      irq_st_q <= (irq_st_q & ~irq_clr) | irq_event_i;
      irq_o    <= |(irq_st_q & irq_en_q);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= R_IDLE;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            s_rdata  <= rd_val;
            s_rresp  <= rd_err ? SLVERR : OKAY;
            s_rvalid <= 1'b1;
            r_state  <= R_DATA;
          end
        end
        default: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{wr_addr[1:0], s_araddr[1:0], en_merged};

endmodule
